alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_pkg.sv | 34 +++
 rtl/muldiv_seq.sv | 120 ++++++++++++
 rtl/alu_md.sv | 156 +++++++++++++++
 tb/tb_alu_md.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU with iterative multiply/divide.
//   func_e  - 4-bit function select codes seen on alu_md.f
//   state_e - mul/div sequencer state (IDLE -> RUN -> FIN -> IDLE)
//   is_md_op() - true for the four codes that launch the sequencer
package alu_pkg;

  typedef enum logic [3:0] {
    F_AND   = 4'd0,
    F_OR    = 4'd1,
    F_ADD   = 4'd2,
    F_MFHI  = 4'd3,
    F_ANDN  = 4'd4,
    F_ORN   = 4'd5,
    F_SUB   = 4'd6,
    F_SLT   = 4'd7,
    F_MULTU = 4'd8,
    F_MULT  = 4'd9,
    F_DIVU  = 4'd10,
    F_DIV   = 4'd11,
    F_MFLO  = 4'd12
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Codes 8..11 share the pattern 4'b10xx.
  function automatic logic is_md_op(input logic [3:0] f);
    return (f[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned engine, one step per RUN cycle.
//   Multiply: shift-add, {acc_hi, acc_lo} holds partial product / multiplier.
//   Divide:   restoring shift-subtract, acc_hi = partial remainder,
//             acc_lo = dividend shifting out / quotient shifting in.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   launch_i         accepted start (caller guarantees state_o == S_IDLE)
//   is_div_i         1 = divide, 0 = multiply (sampled with launch_i)
//   op_a_i, op_b_i   operand magnitudes (sampled with launch_i)
//   state_o          sequencer state (also used for busy/done decode)
//   fin_load_o       high in the last RUN cycle: res_*_o are final this edge
//   res_hi_o/lo_o    accumulator value after the current step (next-state)
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             launch_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output state_e           state_o,
  output logic             fin_load_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One datapath step computed from the current accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_rs   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // Extra top bit gives a clean borrow flag for the trial subtraction.
    div_diff = {1'b0, div_rs} - {2'b00, opb_q};
    div_ge   = ~div_diff[WIDTH+1];
    if (is_div_q) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    case (state_q)
      S_IDLE: begin
        if (launch_i) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = op_a_i;
          opb_d    = op_b_i;
          is_div_d = is_div_i;
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
    end
  end

  assign state_o    = state_q;
  assign fin_load_o = (state_q == S_RUN) && (cnt_q == LAST);
  assign res_hi_o   = step_hi;
  assign res_lo_o   = step_lo;

endmodule

// File: rtl/alu_md.sv
// alu_md: combinational ALU plus iterative multiply/divide with HI/LO.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   a, b        WIDTH-bit operands
//   f           function select (see alu_pkg::func_e)
//   start       launch request for codes 8..11, accepted only when idle
//   y           combinational result of a, b, f, hi, lo
//   hi, lo      registered product halves / remainder, quotient
//   busy        high during the WIDTH RUN cycles
//   done        one-cycle pulse; hi/lo already hold the new result
// Handshake: start is a request sampled on the rising edge; it is accepted
// only when the sequencer is idle and f selects a mul/div code, otherwise it
// is dropped. There is no backpressure: done pulses exactly once per accepted
// start and the consumer must capture or use hi/lo via f=3/12 afterwards.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e           eng_state;
  logic             fin_load;
  logic [WIDTH-1:0] res_hi, res_lo;

  logic             launch;
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_cap_q, a_cap_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;   // negate product / quotient
  logic             neg_hi_q, neg_hi_d;   // negate remainder
  logic             div0_q, div0_d;

  logic [2*WIDTH-1:0] prod_raw, prod_neg;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  // Launch decode and operand magnitudes. Negating the most-negative value
  // yields 2^(WIDTH-1), which is exactly the right unsigned magnitude.
  always_comb begin
    launch    = start && is_md_op(f) && (eng_state == S_IDLE);
    signed_op = (f == F_MULT) || (f == F_DIV);
    a_neg     = signed_op && a[WIDTH-1];
    b_neg     = signed_op && b[WIDTH-1];
    mag_a     = a_neg ? (~a + 1'b1) : a;
    mag_b     = b_neg ? (~b + 1'b1) : b;
  end

  always_comb begin
    a_cap_d  = a_cap_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    if (launch) begin
      a_cap_d  = a;
      is_div_d = f[1];
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = f[1] && a_neg;
      div0_d   = (b == '0);
    end
  end

  // Sign fix-up applied to the engine's final step, so hi/lo load on the
  // same edge the sequencer leaves RUN.
  always_comb begin
    prod_raw = {res_hi, res_lo};
    prod_neg = ~prod_raw + 1'b1;
    if (is_div_q) begin
      if (div0_q) begin
        fin_hi = a_cap_q;
        fin_lo = '1;
      end else begin
        fin_hi = neg_hi_q ? (~res_hi + 1'b1) : res_hi;
        fin_lo = neg_lo_q ? (~res_lo + 1'b1) : res_lo;
      end
    end else begin
      fin_hi = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH] : res_hi;
      fin_lo = neg_lo_q ? prod_neg[WIDTH-1:0]       : res_lo;
    end
    hi_d = fin_load ? fin_hi : hi_q;
    lo_d = fin_load ? fin_lo : lo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      a_cap_q  <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_cap_q  <= a_cap_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
    end
  end

  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk        (clk),
    .reset      (reset),
    .launch_i   (launch),
    .is_div_i   (f[1]),
    .op_a_i     (mag_a),
    .op_b_i     (mag_b),
    .state_o    (eng_state),
    .fin_load_o (fin_load),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo)
  );

  // Combinational result; 3/12 read the registered HI/LO as-is, even while
  // an operation is in flight.
  always_comb begin
    y = '0;
    case (f)
      F_AND:   y = a & b;
      F_OR:    y = a | b;
      F_ADD:   y = a + b;
      F_MFHI:  y = hi_q;
      F_ANDN:  y = a & ~b;
      F_ORN:   y = a | ~b;
      F_SUB:   y = a - b;
      F_SLT:   y = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      F_MFLO:  y = lo_q;
      default: y = '0;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (eng_state == S_RUN);
  assign done = (eng_state == S_FIN);

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed bench for alu_md (WIDTH=32) with an expected-result
// queue for mul/div operations.
module tb_alu_md;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic [3:0]   f;
  logic         start;
  logic [W-1:0] y, hi, lo;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   cur_hi = '0;
  logic [W-1:0]   cur_lo = '0;

  alu_md #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .f     (f),
    .start (start),
    .y     (y),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic logic [W-1:0] y_model(input logic [3:0] ff, input logic [W-1:0] aa, input logic [W-1:0] bb);
    case (ff)
      4'd0:  return aa & bb;
      4'd1:  return aa | bb;
      4'd2:  return aa + bb;
      4'd3:  return cur_hi;
      4'd4:  return aa & ~bb;
      4'd5:  return aa | ~bb;
      4'd6:  return aa - bb;
      4'd7:  return ($signed(aa) < $signed(bb)) ? 32'd1 : 32'd0;
      4'd12: return cur_lo;
      default: return '0;
    endcase
  endfunction

  // Returns {hi, lo}.
  function automatic logic [2*W-1:0] md_model(input logic [3:0] ff, input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [63:0] ua, ub;
    longint      sa, sb, q, r;
    ua = {32'd0, aa};
    ub = {32'd0, bb};
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    case (ff)
      4'd8:  return ua * ub;
      4'd9:  return 64'(sa * sb);
      4'd10: begin
        if (bb == 0) return {aa, 32'hFFFF_FFFF};
        return {aa % bb, aa / bb};
      end
      default: begin
        if (bb == 0) return {aa, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_y(input logic [3:0] ff, input logic [W-1:0] aa, input logic [W-1:0] bb, input string tag);
    @(negedge clk);
    f = ff; a = aa; b = bb;
    #1;
    chk(tag, y, y_model(ff, aa, bb));
  endtask

  task automatic wait_done(input string tag, output int nbusy);
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, hi, e[2*W-1:W]);
      chk({tag, "_lo"}, lo, e[W-1:0]);
      cur_hi = e[2*W-1:W];
      cur_lo = e[W-1:0];
    end
  endtask

  // Launch one mul/div, scramble inputs while busy, check latency and result.
  task automatic run_op(input logic [3:0] ff, input logic [W-1:0] aa, input logic [W-1:0] bb, input string tag);
    int nb;
    @(negedge clk);
    a = aa; b = bb; f = ff; start = 1'b1;
    exp_q.push_back(md_model(ff, aa, bb));
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; f = 4'd3;
    #1;
    chk({tag, "_busy_first"}, busy, 1);
    chk({tag, "_mfhi_while_busy"}, y, cur_hi);
    wait_done(tag, nb);
    chk({tag, "_busy_cycles"}, nb, 32);
    chk({tag, "_done"}, done, 1);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ndone;
    logic [W-1:0] hi_at_done, lo_at_done;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; f = '0;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // Combinational functions.
    check_y(4'd2, 32'd5, 32'd7, "y_add");
    chk("y_add_const", y, 32'd12);
    check_y(4'd7, 32'hFFFF_FFFF, 32'd1, "y_slt");
    chk("y_slt_const", y, 32'd1);
    check_y(4'd6, 32'd0, 32'd1, "y_sub");
    chk("y_sub_const", y, 32'hFFFF_FFFF);
    check_y(4'd7, 32'd1, 32'hFFFF_FFFF, "y_slt_pos");
    check_y(4'd13, 32'hAAAA_5555, 32'h1234_5678, "y_unused_code");
    for (int i = 0; i < 16; i++) begin
      check_y(4'($urandom_range(0, 15)), $urandom, $urandom, "y_rand");
    end

    // start with a non mul/div code is dropped.
    @(negedge clk);
    f = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("ign_start_busy", busy, 0);

    // Mul/div operations.
    run_op(4'd9,  32'hFFFF_FFFD, 32'd7, "mult_neg");
    chk("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
    run_op(4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check_y(4'd3, 32'd0, 32'd0, "mfhi");
    chk("mfhi_const", y, 32'hFFFF_FFFE);
    check_y(4'd12, 32'd0, 32'd0, "mflo");
    chk("mflo_const", y, 32'd1);
    run_op(4'd11, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    run_op(4'd10, 32'h12, 32'd0, "divu_zero");
    chk("divu_zero_hi_const", hi, 32'h12);
    run_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    chk("div_min_m1_lo_const", lo, 32'h8000_0000);
    run_op(4'd11, 32'hFFFF_FF00, 32'd0, "div_zero_neg");
    run_op(4'd9,  32'h8000_0000, 32'h8000_0000, "mult_min");
    run_op(4'd11, 32'd100, 32'hFFFF_FFF9, "div_pos_neg");
    run_op(4'd10, $urandom, $urandom_range(1, 1000), "divu_rand");
    run_op(4'd9,  $urandom, $urandom, "mult_rand");

    // Second start in RUN cycle 5 is ignored.
    @(negedge clk);
    a = 32'h1234; b = 32'h5678; f = 4'd8; start = 1'b1;
    exp_q.push_back(md_model(4'd8, 32'h1234, 32'h5678));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'd99; b = 32'd99; f = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; hi_at_done = '0; lo_at_done = '0;
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) begin
        ndone++;
        hi_at_done = hi;
        lo_at_done = lo;
      end
      @(negedge clk);
    end
    chk("restart_done_count", ndone, 1);
    begin
      logic [2*W-1:0] e;
      e = exp_q.pop_front();
      chk("restart_hi", hi_at_done, e[2*W-1:W]);
      chk("restart_lo", lo_at_done, e[W-1:0]);
      cur_hi = e[2*W-1:W];
      cur_lo = e[W-1:0];
    end

    // Reset in RUN cycle 10 aborts the operation.
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0001_2345; f = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_hi_kept", hi, 0);
    run_op(4'd8, 32'd3, 32'd4, "multu_after_reset");
    chk("multu_after_reset_lo_const", lo, 32'd12);
    chk("multu_after_reset_hi_const", hi, 32'd0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
